dsp_addsub_seq: RTL and testbench

- Parametrised, chunk-serial add/subtract unit for the sail-core datapath.
- Processes operands of WIDTH bits CHUNK bits per cycle through one CHUNK-bit adder slice, with a registered carry between chunks. For CHUNK=16, that slice maps onto a single SB_MAC16 add/sub half.
- Adds a valid/ready handshake, an ADD/SUB mode select, and full status flags (carry, overflow, zero, negative, signed/unsigned less-than) for branch compare and wide arithmetic.

---
 rtl/dsp_pkg.sv | 17 +
 rtl/dsp_addsub_slice.sv | 26 ++
 rtl/dsp_addsub_seq.sv | 116 +++++++++++
 tb/tb_dsp_addsub_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared state encoding, op codes and chunk-count helper for the add/sub unit
package dsp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/dsp_addsub_slice.sv
// rtl/dsp_addsub_slice.sv - one CHUNK-bit add/sub slice with carry in/out and signed overflow
module dsp_addsub_slice #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [CHUNK-1:0] bx;
  logic [CHUNK:0]   full;

  // Subtraction is a + ~b with the +1 supplied through cin by the caller.
  always_comb begin
    bx   = b ^ {CHUNK{sub}};
    full = {1'b0, a} + {1'b0, bx} + {{CHUNK{1'b0}}, cin};
    sum  = full[CHUNK-1:0];
    cout = full[CHUNK];
    ovf  = (a[CHUNK-1] == bx[CHUNK-1]) && (sum[CHUNK-1] != a[CHUNK-1]);
  end

endmodule

// File: rtl/dsp_addsub_seq.sv
// rtl/dsp_addsub_seq.sv - chunk-serial add/subtract with valid/ready handshake and status flags
module dsp_addsub_seq
  import dsp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             lt,
  output logic             ltu
);

  localparam int NCH = nchunk(WIDTH, CHUNK);
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_next;
  logic             sub_q;
  logic             cy_q;
  logic [CHUNK-1:0] s_a;
  logic [CHUNK-1:0] s_b;
  logic [CHUNK-1:0] s_sum;
  logic             s_cout;
  logic             s_ovf;
  logic             accept;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign result    = res_q;

  always_comb begin
    s_a      = a_q[int'(cnt)*CHUNK +: CHUNK];
    s_b      = b_q[int'(cnt)*CHUNK +: CHUNK];
    res_next = res_q;
    res_next[int'(cnt)*CHUNK +: CHUNK] = s_sum;
  end

  dsp_addsub_slice #(
    .CHUNK(CHUNK)
  ) u_slice (
    .a   (s_a),
    .b   (s_b),
    .sub (sub_q),
    .cin (cy_q),
    .sum (s_sum),
    .cout(s_cout),
    .ovf (s_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      sub_q    <= OP_ADD;
      cy_q     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      lt       <= 1'b0;
      ltu      <= 1'b0;
    end else if (accept) begin
      // Operands are captured so a/b/op_sub may change during RUN.
      a_q   <= a;
      b_q   <= b;
      sub_q <= op_sub;
      cy_q  <= op_sub;
      cnt   <= '0;
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          res_q <= res_next;
          cy_q  <= s_cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= DONE;
            carry    <= s_cout;
            overflow <= s_ovf;
            zero     <= ~|res_next;
            negative <= res_next[WIDTH-1];
            lt       <= (sub_q == OP_SUB) & (res_next[WIDTH-1] ^ s_ovf);
            ltu      <= (sub_q == OP_SUB) & ~s_cout;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_addsub_seq.sv
// tb/tb_dsp_addsub_seq.sv - directed self-checking bench for dsp_addsub_seq at 32/16, 64/16 and 16/16
module tb_dsp_addsub_seq;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic        iv32, ir32, sub32, v32, rdy32, c32, ov32, z32, n32, lt32, ltu32;
  logic [31:0] a32, b32, res32;
  logic        iv64, ir64, sub64, v64, rdy64, c64, ov64, z64, n64, lt64, ltu64;
  logic [63:0] a64, b64, res64;
  logic        iv16, ir16, sub16, v16, rdy16, c16, ov16, z16, n16, lt16, ltu16;
  logic [15:0] a16, b16, res16;
  logic [5:0]  f32, f64, f16;

  assign f32 = {c32, ov32, z32, n32, lt32, ltu32};
  assign f64 = {c64, ov64, z64, n64, lt64, ltu64};
  assign f16 = {c16, ov16, z16, n16, lt16, ltu16};

  dsp_addsub_seq #(.WIDTH(32), .CHUNK(16)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .op_sub(sub32),
    .a(a32), .b(b32), .out_valid(v32), .out_ready(rdy32), .result(res32),
    .carry(c32), .overflow(ov32), .zero(z32), .negative(n32), .lt(lt32), .ltu(ltu32)
  );

  dsp_addsub_seq #(.WIDTH(64), .CHUNK(16)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .op_sub(sub64),
    .a(a64), .b(b64), .out_valid(v64), .out_ready(rdy64), .result(res64),
    .carry(c64), .overflow(ov64), .zero(z64), .negative(n64), .lt(lt64), .ltu(ltu64)
  );

  dsp_addsub_seq #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .op_sub(sub16),
    .a(a16), .b(b16), .out_valid(v16), .out_ready(rdy16), .result(res16),
    .carry(c16), .overflow(ov16), .zero(z16), .negative(n16), .lt(lt16), .ltu(ltu16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start32(input logic s, input logic [31:0] aa, input logic [31:0] bb);
    iv32 = 1'b1; sub32 = s; a32 = aa; b32 = bb;
    step();
    iv32 = 1'b0; a32 = 32'hDEADBEEF; b32 = 32'h0BADF00D; sub32 = ~s;
  endtask

  task automatic wait_valid(input int which, output int lat);
    lat = 0;
    while (!(which == 0 ? v32 : (which == 1 ? v64 : v16)) && lat < 50) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({ir32, ir64, ir16} !== 3'b111) begin
      errors++; $display("FAIL reset_in_ready got %b want 111", {ir32, ir64, ir16});
    end
    checks++;
    if ({v32, res32, f32} !== 39'd0) begin
      errors++; $display("FAIL reset_out32 got v=%b r=%h f=%b want all zero", v32, res32, f32);
    end
    checks++;
    if ({v64, res64, f64, v16, res16, f16} !== 95'd0) begin
      errors++; $display("FAIL reset_out64_16 got v64=%b r64=%h f64=%b v16=%b r16=%h f16=%b want all zero",
                         v64, res64, f64, v16, res16, f16);
    end
  endtask

  task automatic test_add_carry();
    int lat;
    start32(1'b0, 32'h0000FFFF, 32'h00000001);
    wait_valid(0, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL add_latency got %0d want 2", lat); end
    checks++;
    if (res32 !== 32'h00010000) begin errors++; $display("FAIL add_result got %h want 00010000", res32); end
    checks++;
    if (f32 !== 6'b000000) begin errors++; $display("FAIL add_flags got %b want 000000", f32); end
    step();
    checks++;
    if ({v32, ir32} !== 2'b01) begin errors++; $display("FAIL add_drain got v/ir=%b want 01", {v32, ir32}); end
  endtask

  task automatic test_sub_negative();
    int lat;
    start32(1'b1, 32'h00000005, 32'h00000007);
    wait_valid(0, lat);
    checks++;
    if (res32 !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_result got %h want fffffffe", res32); end
    checks++;
    if (f32 !== 6'b000111) begin errors++; $display("FAIL sub_flags got %b want 000111", f32); end
    step();
  endtask

  task automatic test_overflow_zero();
    int lat;
    start32(1'b0, 32'h7FFFFFFF, 32'h00000001);
    wait_valid(0, lat);
    checks++;
    if (res32 !== 32'h80000000) begin errors++; $display("FAIL ovf_result got %h want 80000000", res32); end
    checks++;
    if (f32 !== 6'b010100) begin errors++; $display("FAIL ovf_flags got %b want 010100", f32); end
    step();
    start32(1'b1, 32'h12345678, 32'h12345678);
    wait_valid(0, lat);
    checks++;
    if (res32 !== 32'h00000000) begin errors++; $display("FAIL eq_result got %h want 00000000", res32); end
    checks++;
    if (f32 !== 6'b101000) begin errors++; $display("FAIL eq_flags got %b want 101000", f32); end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    rdy32 = 1'b0;
    start32(1'b1, 32'h00000005, 32'h00000007);
    wait_valid(0, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL bp_latency got %0d want 2", lat); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({v32, ir32, res32, f32} !== {1'b1, 1'b0, 32'hFFFFFFFE, 6'b000111}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%b ir=%b r=%h f=%b want v=1 ir=0 r=fffffffe f=000111",
                 i, v32, ir32, res32, f32);
      end
    end
    rdy32 = 1'b1;
    iv32 = 1'b1; sub32 = 1'b0; a32 = 32'd1; b32 = 32'd2;
    #1;
    checks++;
    if (ir32 !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", ir32); end
    step();
    iv32 = 1'b0; a32 = 32'hFFFFFFFF; b32 = 32'hFFFFFFFF;
    checks++;
    if (v32 !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got %b want 0", v32); end
    wait_valid(0, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL b2b_latency got %0d want 2", lat); end
    checks++;
    if ({res32, f32} !== {32'h00000003, 6'b000000}) begin
      errors++; $display("FAIL b2b_result got r=%h f=%b want r=00000003 f=000000", res32, f32);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic seen;
    start32(1'b0, 32'h0000FFFF, 32'h00000001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({v32, ir32, res32, f32} !== {1'b0, 1'b1, 32'h0, 6'b0}) begin
      errors++; $display("FAIL midrst_state got v=%b ir=%b r=%h f=%b want v=0 ir=1 r=0 f=0",
                         v32, ir32, res32, f32);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen = seen | v32;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midrst_stale got out_valid=%b want 0", seen); end
  endtask

  task automatic test_wide64();
    int lat;
    iv64 = 1'b1; sub64 = 1'b0; a64 = 64'hFFFFFFFFFFFFFFFF; b64 = 64'd1;
    step();
    iv64 = 1'b0; a64 = '0; b64 = '0;
    wait_valid(1, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL w64_latency got %0d want 4", lat); end
    checks++;
    if ({res64, f64} !== {64'd0, 6'b101000}) begin
      errors++; $display("FAIL w64_result got r=%h f=%b want r=0 f=101000", res64, f64);
    end
    step();
  endtask

  task automatic test_narrow16();
    int lat;
    iv16 = 1'b1; sub16 = 1'b1; a16 = 16'h8000; b16 = 16'h0001;
    step();
    iv16 = 1'b0; sub16 = 1'b0; a16 = '0;
    wait_valid(2, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL n16_latency got %0d want 1", lat); end
    checks++;
    if ({res16, f16} !== {16'h7FFF, 6'b110010}) begin
      errors++; $display("FAIL n16_result got r=%h f=%b want r=7fff f=110010", res16, f16);
    end
    step();
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b0;
    iv32 = 1'b0; sub32 = 1'b0; a32 = '0; b32 = '0; rdy32 = 1'b1;
    iv64 = 1'b0; sub64 = 1'b0; a64 = '0; b64 = '0; rdy64 = 1'b1;
    iv16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0; rdy16 = 1'b1;
    test_reset();
    test_add_carry();
    test_sub_negative();
    test_overflow_zero();
    test_back_to_back();
    test_reset_mid();
    test_wide64();
    test_narrow16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
